// File: rtl/riscv_mpsoc_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, predictor FSM
// states and the saturating counter update.
package riscv_mpsoc_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    typedef enum logic {
        INIT,
        RUN
    } bp_state_t;

    function automatic logic [1:0] bp_next_cnt(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == BP_ST) ? BP_ST : cnt + 2'b01;
        else
            return (cnt == BP_SNT) ? BP_SNT : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/riscv_bp_ram.sv
// Pattern history table storage: simple dual-port RAM, one write port and one
// registered read port with enable. No reset; contents are set by the init sweep.
module riscv_bp_ram #(
    parameter int ABITS = 12,
    parameter int DEPTH = 2**ABITS
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [1:0]       wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [1:0]       rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/riscv_gshare_bp.sv
// Gshare branch predictor: PHT indexed by {global history, PC bits}, 1-cycle
// read to fetch, counter write-back from the branch unit, post-reset init sweep.
module riscv_gshare_bp
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_stall,
    input  logic [XLEN-1:0]           if_parcel_pc,
    input  logic [BP_GLOBAL_BITS-1:0] if_bp_history,
    output logic [1:0]                bp_bp_predict,
    output logic                      bp_init_busy,
    input  logic [XLEN-1:0]           ex_pc,
    input  logic                      bu_bp_update,
    input  logic                      bu_bp_btaken,
    input  logic [1:0]                bu_bp_predict,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history
);

    localparam int ABITS = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int DEPTH = 2**ABITS;

    bp_state_t        state, state_nxt;
    logic [ABITS-1:0] init_cnt, init_cnt_nxt;
    logic [ABITS-1:0] ridx, widx, waddr;
    logic [1:0]       wdata, ram_rdata, fwd_data;
    logic             we, re, fwd_hit;

    assign ridx = {if_bp_history, if_parcel_pc[BP_LOCAL_BITS+1:2]};
    assign widx = {bu_bp_history, ex_pc[BP_LOCAL_BITS+1:2]};

    // Upper and lower PC bits are deliberately dropped; aliasing is intended.
    logic unused;
    assign unused = ^{if_parcel_pc[XLEN-1:BP_LOCAL_BITS+2], if_parcel_pc[1:0],
                      ex_pc[XLEN-1:BP_LOCAL_BITS+2], ex_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        we           = 1'b0;
        waddr        = widx;
        wdata        = bp_next_cnt(bu_bp_predict, bu_bp_btaken);
        case (state)
            INIT: begin
                we           = 1'b1;
                waddr        = init_cnt;
                wdata        = BP_WNT;
                init_cnt_nxt = init_cnt + 1'b1;
                if (init_cnt == '1) state_nxt = RUN;
            end
            RUN:     we = bu_bp_update;
            default: state_nxt = INIT;
        endcase
    end

    // Reads keep running during the sweep so the first RUN cycle already
    // shows a valid entry even if fetch is stalled across the sweep end.
    assign re = !if_stall || (state == INIT);

    riscv_bp_ram #(.ABITS(ABITS), .DEPTH(DEPTH)) u_pht (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (ridx),
        .rdata (ram_rdata)
    );

    // Write-first: a same-cycle write to the read index overrides the RAM's old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit  <= 1'b0;
            fwd_data <= BP_SNT;
        end else if (re) begin
            fwd_hit  <= we && (waddr == ridx);
            fwd_data <= wdata;
        end
    end

    assign bp_init_busy  = (state == INIT);
    assign bp_bp_predict = (state == INIT) ? BP_SNT : (fwd_hit ? fwd_data : ram_rdata);

endmodule

// File: tb/tb_riscv_gshare_bp.sv
// Self-checking bench for riscv_gshare_bp: directed scenarios then random
// traffic, all checked against an array-based model of the PHT.
module tb_riscv_gshare_bp;

    localparam int XLEN  = 32;
    localparam int GB    = 2;
    localparam int LB    = 4;
    localparam int DEPTH = 64;

    logic            clk;
    logic            rst;
    logic            if_stall;
    logic [XLEN-1:0] if_parcel_pc;
    logic [GB-1:0]   if_bp_history;
    logic [1:0]      bp_bp_predict;
    logic            bp_init_busy;
    logic [XLEN-1:0] ex_pc;
    logic            bu_bp_update;
    logic            bu_bp_btaken;
    logic [1:0]      bu_bp_predict;
    logic [GB-1:0]   bu_bp_history;

    riscv_gshare_bp #(.XLEN(XLEN), .BP_GLOBAL_BITS(GB), .BP_LOCAL_BITS(LB)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall      (if_stall),
        .if_parcel_pc  (if_parcel_pc),
        .if_bp_history (if_bp_history),
        .bp_bp_predict (bp_bp_predict),
        .bp_init_busy  (bp_init_busy),
        .ex_pc         (ex_pc),
        .bu_bp_update  (bu_bp_update),
        .bu_bp_btaken  (bu_bp_btaken),
        .bu_bp_predict (bu_bp_predict),
        .bu_bp_history (bu_bp_history)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: table of counters, sweep progress and the last value read.
    int pht [DEPTH];
    int init_left = DEPTH;
    int exp_q     = 0;

    function automatic int idx_of(input logic [XLEN-1:0] pc, input int hist);
        return hist * 16 + ((pc / 4) % 16);
    endfunction

    function automatic int sat(input int p, input logic taken);
        if (taken) return (p < 3) ? p + 1 : 3;
        return (p > 0) ? p - 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic busy_e;
        busy_e = rst || (init_left > 0);
        check({tag, "_busy"}, {1'b0, bp_init_busy}, {1'b0, busy_e});
        check({tag, "_pred"}, bp_bp_predict, busy_e ? 2'd0 : 2'(exp_q));
    endtask

    // One clock: advance the model with the inputs that were present at the edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            init_left = DEPTH;
        end else begin
            if (init_left > 0) begin
                pht[DEPTH - init_left] = 1;
                init_left--;
            end else if (bu_bp_update) begin
                pht[idx_of(ex_pc, int'(bu_bp_history))] = sat(int'(bu_bp_predict), bu_bp_btaken);
            end
            if (!if_stall) exp_q = pht[idx_of(if_parcel_pc, int'(if_bp_history))];
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic set_read(input logic [XLEN-1:0] pc, input logic [GB-1:0] h);
        if_parcel_pc  = pc;
        if_bp_history = h;
    endtask

    task automatic set_upd(input logic u, input logic [XLEN-1:0] pc, input logic [GB-1:0] h,
                           input logic [1:0] p, input logic t);
        bu_bp_update  = u;
        ex_pc         = pc;
        bu_bp_history = h;
        bu_bp_predict = p;
        bu_bp_btaken  = t;
    endtask

    initial begin
        logic [1:0] held;
        for (int i = 0; i < DEPTH; i++) pht[i] = 3;
        rst      = 1'b1;
        if_stall = 1'b0;
        set_read(32'h0, 2'd0);
        set_upd(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        #1;
        check_outputs("rst_async");
        step("rst_hold");
        rst = 1'b0;

        // 1: full sweep, then every entry reads weakly not-taken
        for (int i = 0; i < DEPTH; i++) step("sweep");
        check("sweep_done", {1'b0, bp_init_busy}, 2'd0);
        for (int i = 0; i < 8; i++) begin
            set_read($urandom, 2'($urandom_range(3)));
            step("post_init");
            check("post_init_wnt", bp_bp_predict, 2'b01);
        end

        // 2: increment, saturate high, saturate low
        set_upd(1'b1, 32'h100, 2'b10, 2'b01, 1'b1);
        step("inc_wr");
        set_upd(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        set_read(32'h100, 2'b10);
        step("inc_rd");
        check("inc_val", bp_bp_predict, 2'b10);
        set_upd(1'b1, 32'h100, 2'b10, 2'b11, 1'b1);
        step("sat_hi");
        check("sat_hi_val", bp_bp_predict, 2'b11);
        set_upd(1'b1, 32'h100, 2'b10, 2'b00, 1'b0);
        step("sat_lo");
        check("sat_lo_val", bp_bp_predict, 2'b00);

        // 3: same-index collision forwards, different index does not
        set_read(32'h40, 2'b01);
        set_upd(1'b1, 32'h40, 2'b01, 2'b01, 1'b1);
        step("coll_same");
        check("coll_same_val", bp_bp_predict, 2'b10);
        set_read(32'h48, 2'b01);
        set_upd(1'b1, 32'h4c, 2'b01, 2'b01, 1'b1);
        step("coll_diff");
        check("coll_diff_val", bp_bp_predict, 2'b01);
        set_upd(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);

        // 4: stall holds the output while the PC moves
        set_read(32'h40, 2'b01);
        step("stall_pre");
        held = bp_bp_predict;
        if_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_read(32'h200 + 32'(i * 4), 2'b00);
            step("stall");
            check("stall_hold", bp_bp_predict, held);
        end
        if_stall = 1'b0;
        step("stall_rel");
        check("stall_rel_val", bp_bp_predict, 2'b01);

        // 5: reset mid-sweep restarts it; an update during INIT is dropped
        rst = 1'b1;
        #1;
        check_outputs("rst_run");
        step("rst_run_hold");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step("sweep2");
        rst = 1'b1;
        #1;
        check_outputs("rst_mid");
        step("rst_mid_hold");
        rst = 1'b0;
        set_upd(1'b1, 32'h100, 2'b10, 2'b01, 1'b1);
        step("init_upd");
        set_upd(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        for (int i = 1; i < DEPTH; i++) step("sweep3");
        check("sweep3_done", {1'b0, bp_init_busy}, 2'd0);
        set_read(32'h100, 2'b10);
        step("init_upd_rd");
        check("init_upd_dropped", bp_bp_predict, 2'b01);

        // 6: aliasing through ignored PC bits
        set_upd(1'b1, 32'h104, 2'b00, 2'b01, 1'b1);
        step("alias_wr");
        set_upd(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        set_read(32'h144, 2'b00);
        step("alias_rd");
        check("alias_val", bp_bp_predict, 2'b10);

        // Random traffic, with frequent same-index read/write pairs
        for (int i = 0; i < 600; i++) begin
            if_stall = ($urandom_range(3) == 0);
            set_read($urandom, 2'($urandom_range(3)));
            if ($urandom_range(1) == 1)
                set_upd(1'($urandom_range(1)), if_parcel_pc ^ 32'($urandom_range(3)) ^ 32'hF000_0000,
                        if_bp_history, 2'($urandom_range(3)), 1'($urandom_range(1)));
            else
                set_upd(1'($urandom_range(1)), $urandom, 2'($urandom_range(3)),
                        2'($urandom_range(3)), 1'($urandom_range(1)));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/riscv_gshare_bp.md
Name: riscv_gshare_bp

Overview:
- Gshare branch predictor sitting directly downstream of the branch unit.
- Provides a 2-bit prediction counter to the fetch stage for every parcel PC; fetch carries it through decode as id_bp_predict.
- Consumes the branch unit's resolution outputs (bu_bp_update/btaken/predict/history) and writes back an updated saturating counter.
- Includes a post-reset table-initialisation sweep.

Parameters:
- XLEN, 64, program counter width.
- BP_GLOBAL_BITS, 2, global history bits in the index.
- BP_LOCAL_BITS, 10, PC bits in the index; PC bits taken are [BP_LOCAL_BITS+1:2].
- DEPTH, 2**(BP_GLOBAL_BITS+BP_LOCAL_BITS), pattern history table (PHT) entries. Derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_stall  in  1  fetch stall; holds the prediction output.
- if_parcel_pc  in  XLEN  PC being fetched.
- if_bp_history  in  BP_GLOBAL_BITS  current global history from the branch unit.
- bp_bp_predict  out  2  counter for the fetched PC; bit1=predict taken.
- bp_init_busy  out  1  high while the PHT init sweep runs.
- ex_pc  in  XLEN  PC of the branch being resolved (aligned with bu_* outputs).
- bu_bp_update  in  1  resolved conditional branch this cycle.
- bu_bp_btaken  in  1  actual outcome.
- bu_bp_predict  in  2  counter value originally read for that branch.
- bu_bp_history  in  BP_GLOBAL_BITS  history used when that branch was predicted.

Behaviour:
- Index function: idx = {history, pc[BP_LOCAL_BITS+1:2]}.
  - Read index uses if_bp_history and if_parcel_pc.
  - Write index uses bu_bp_history and ex_pc.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Next counter value:
  - bu_bp_btaken=1: saturating increment of bu_bp_predict (11 stays 11).
  - bu_bp_btaken=0: saturating decrement (00 stays 00).
  - The counter is computed from bu_bp_predict; the PHT is not re-read.
- FSM states INIT and RUN.
  - On rst assertion, asynchronously: state=INIT, init_cnt=0, bp_bp_predict=2'b00, bp_init_busy=1.
  - INIT: each cycle write 2'b01 to PHT[init_cnt], then init_cnt++. Go to RUN on the edge that writes DEPTH-1, so bp_init_busy is high for exactly DEPTH cycles after rst deasserts.
  - In INIT, bu_bp_update writes are dropped and bp_bp_predict is forced to 2'b00.
  - RUN: stays in RUN until rst. rst mid-sweep or mid-run restarts the sweep from entry 0.
- Read path has 1-cycle latency.
  - When !if_stall, bp_bp_predict at edge N+1 = PHT[read idx sampled at edge N].
  - When if_stall=1, bp_bp_predict holds its value and the read address is not advanced.
- Write: in RUN with bu_bp_update=1, the next counter is written to PHT[write idx] at the edge.
- Collision: if a write and an unstalled read hit the same index in the same cycle, bp_bp_predict takes the newly written value (write-first forwarding). Differing indices are independent.
- if_stall and bu_bp_update together: the write proceeds, the output holds.
- While if_stall is held, no refresh of the output from a later write is required.
- All index arithmetic is truncation only; PC bits above BP_LOCAL_BITS+1 and bits [1:0] are ignored, so aliasing is intended.

Decomposition:
- Shared package riscv_mpsoc_pkg holds:
  - the counter-encoding constants BP_SNT, BP_WNT, BP_WT, BP_ST;
  - the FSM state typedef (INIT/RUN).
- One sub-module, riscv_bp_ram: DEPTH x 2 simple dual-port RAM with one write port, one registered read port and a read-enable.
  - It has no reset.
  - Collision forwarding is done in riscv_gshare_bp, not in the RAM.

Test Plan (XLEN=32, BP_GLOBAL_BITS=2, BP_LOCAL_BITS=4, DEPTH=64):
1. Pulse rst, release -> bp_init_busy high for exactly 64 cycles; bp_bp_predict=00 throughout; afterwards a read of any PC with any history returns 01.
2. In RUN, update ex_pc=0x100, history=2'b10, predict=01, btaken=1 -> next read of pc=0x100 with history 2'b10 returns 10. Repeat the update with predict=11 -> stays 11. Decrement from 00 with btaken=0 -> stays 00.
3. Same cycle: read pc=0x40, history 01, and update the same index from 01 with btaken=1 -> bp_bp_predict=10 on the next cycle. A different-index write leaves the read at 01.
4. Hold if_stall=1 for 3 cycles while if_parcel_pc changes -> bp_bp_predict is unchanged; after release the output reflects the new PC one cycle later.
5. Assert rst at sweep count 20 for 1 cycle -> outputs go to 00/busy=1 immediately; after release, busy lasts 64 more cycles. An update issued during INIT is not visible afterwards (entry reads 01).
6. Aliasing: pc 0x104 and 0x144 with the same history (index bits [5:2] equal, history equal) -> an update to one is observed on the other.
